// File: rtl/mem_access_if.sv
// Data-memory port between the memory-access stage and the data memory.
// The stage (master) issues registered requests; the memory (slave)
// answers with read data and a one-cycle acknowledge.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage of a 5-stage MIPS pipeline. Issues req/ack data
// memory accesses, stalls upstream while an access is outstanding,
// abandons an access after TIMEOUT unacknowledged cycles, resolves
// branches, and holds the MEM/WB pipeline register.
module mem_access #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        res,
  input  logic [31:0]        write_data_ex,
  input  logic [4:0]         write_register_ex,
  input  logic [2:0]         m_MEM,
  input  logic [1:0]         wb_MEM,
  input  logic               zero,
  mem_access_if.master       dmem,
  output logic               stall_mem,
  output logic               pc_src,
  output logic [31:0]        read_data_wb,
  output logic [31:0]        alu_res_wb,
  output logic [4:0]         rd_WB,
  output logic [1:0]         wb_WB,
  output logic [31:0]        write_data_reg,
  output logic               misalign,
  output logic               bus_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_wb_q, rdata_wb_d;
  logic [31:0]     alu_wb_q, alu_wb_d;
  logic [4:0]      rd_wb_q, rd_wb_d;
  logic [1:0]      wbc_wb_q, wbc_wb_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  logic            acc_s;
  logic            aligned_s;
  logic            timeout_s;

  assign acc_s     = m_MEM[1] | m_MEM[0];
  assign aligned_s = (res[1:0] == 2'b00);
  assign timeout_s = (cnt_q == TW'(TIMEOUT));

  // Next-state, stall and MEM/WB update logic for the IDLE/BUSY controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_wb_d = rdata_wb_q;
    alu_wb_d   = alu_wb_q;
    rd_wb_d    = rd_wb_q;
    wbc_wb_d   = wbc_wb_q;
    misalign_d = 1'b0;
    bus_err_d  = bus_err_q;
    stall_mem  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!acc_s) begin
          // plain ALU op: single-cycle pass-through into MEM/WB
          alu_wb_d = res;
          rd_wb_d  = write_register_ex;
          wbc_wb_d = wb_MEM;
        end else if (!aligned_s) begin
          // misaligned access is dropped and replaced by a bubble
          misalign_d = 1'b1;
          wbc_wb_d   = 2'b00;
        end else begin
          // launch request; a write wins if both read and write are set
          stall_mem = 1'b1;
          req_d     = 1'b1;
          we_d      = m_MEM[0];
          addr_d    = res;
          wdata_d   = write_data_ex;
          cnt_d     = {TW{1'b0}};
          wbc_wb_d  = 2'b00;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall_mem = ~dmem.dmem_ack & ~timeout_s;
        if (dmem.dmem_ack) begin
          // ack has priority over a coincident timeout
          if (!we_q) begin
            rdata_wb_d = dmem.dmem_rdata;
          end else begin
            rdata_wb_d = rdata_wb_q;
          end
          alu_wb_d = res;
          rd_wb_d  = write_register_ex;
          wbc_wb_d = wb_MEM;
          req_d    = 1'b0;
          state_d  = IDLE;
        end else if (timeout_s) begin
          bus_err_d = 1'b1;
          req_d     = 1'b0;
          wbc_wb_d  = 2'b00;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Pipeline/state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {TW{1'b0}};
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      rdata_wb_q <= 32'h0000_0000;
      alu_wb_q   <= 32'h0000_0000;
      rd_wb_q    <= 5'd0;
      wbc_wb_q   <= 2'b00;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_wb_q <= rdata_wb_d;
      alu_wb_q   <= alu_wb_d;
      rd_wb_q    <= rd_wb_d;
      wbc_wb_q   <= wbc_wb_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign read_data_wb   = rdata_wb_q;
  assign alu_res_wb     = alu_wb_q;
  assign rd_WB          = rd_wb_q;
  assign wb_WB          = wbc_wb_q;
  assign misalign       = misalign_q;
  assign bus_err        = bus_err_q;

  // branch resolves only when no memory access is outstanding
  assign pc_src         = m_MEM[2] & zero & (state_q == IDLE);
  assign write_data_reg = wbc_wb_q[0] ? rdata_wb_q : alu_wb_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed stimulus, a transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_mem_access;
  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] res;
  logic [31:0] wd;
  logic [4:0]  wr;
  logic [2:0]  m;
  logic [1:0]  wbm;
  logic        zero;
  logic        ack;
  logic [31:0] rdata;
  logic        stall_mem, pc_src, misalign, bus_err;
  logic [31:0] read_data_wb, alu_res_wb, write_data_reg;
  logic [4:0]  rd_WB;
  logic [1:0]  wb_WB;

  int total = 0;
  int bad   = 0;
  logic cmp_en = 1'b0;

  mem_access_if bus ();
  assign bus.dmem_ack   = ack;
  assign bus.dmem_rdata = rdata;

  mem_access #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst), .res(res), .write_data_ex(wd),
    .write_register_ex(wr), .m_MEM(m), .wb_MEM(wbm), .zero(zero),
    .dmem(bus), .stall_mem(stall_mem), .pc_src(pc_src),
    .read_data_wb(read_data_wb), .alu_res_wb(alu_res_wb), .rd_WB(rd_WB),
    .wb_WB(wb_WB), .write_data_reg(write_data_reg), .misalign(misalign),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access at a time, tracked by how long it has waited.
  logic        m_busy;
  int          m_wait;
  logic        m_req, m_we, m_mis, m_err;
  logic [31:0] m_addr, m_wdata, m_rdwb, m_alu;
  logic [4:0]  m_rd;
  logic [1:0]  m_wb;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_wait <= 0; m_req <= 1'b0; m_we <= 1'b0;
      m_addr <= 32'd0; m_wdata <= 32'd0; m_rdwb <= 32'd0; m_alu <= 32'd0;
      m_rd <= 5'd0; m_wb <= 2'b00; m_mis <= 1'b0; m_err <= 1'b0;
    end else begin
      m_mis <= 1'b0;
      if (!m_busy) begin
        if (m == 3'b000 || m == 3'b100) begin
          m_alu <= res; m_rd <= wr; m_wb <= wbm;
        end else if (res % 4 != 0) begin
          m_mis <= 1'b1; m_wb <= 2'b00;
        end else begin
          m_busy <= 1'b1; m_wait <= 0; m_req <= 1'b1; m_we <= m[0];
          m_addr <= res; m_wdata <= wd; m_wb <= 2'b00;
        end
      end else if (ack) begin
        if (!m_we) m_rdwb <= rdata;
        m_alu <= res; m_rd <= wr; m_wb <= wbm; m_req <= 1'b0; m_busy <= 1'b0;
      end else if (m_wait == TO) begin
        m_err <= 1'b1; m_req <= 1'b0; m_wb <= 2'b00; m_busy <= 1'b0;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    logic e_stall;
    if (cmp_en) begin
      if (m_busy) e_stall = !ack && (m_wait != TO);
      else        e_stall = (m[1] || m[0]) && (res % 4 == 0);
      chk("stall_mem", {31'd0, stall_mem}, {31'd0, e_stall});
      chk("pc_src", {31'd0, pc_src}, {31'd0, m[2] && zero && !m_busy});
      chk("dmem_req", {31'd0, bus.dmem_req}, {31'd0, m_req});
      chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, m_we});
      chk("dmem_addr", bus.dmem_addr, m_addr);
      chk("dmem_wdata", bus.dmem_wdata, m_wdata);
      chk("read_data_wb", read_data_wb, m_rdwb);
      chk("alu_res_wb", alu_res_wb, m_alu);
      chk("rd_WB", {27'd0, rd_WB}, {27'd0, m_rd});
      chk("wb_WB", {30'd0, wb_WB}, {30'd0, m_wb});
      chk("write_data_reg", write_data_reg, m_wb[0] ? m_rdwb : m_alu);
      chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
      chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res = 32'd0; wd = 32'd0; wr = 5'd0; m = 3'b000; wbm = 2'b00; zero = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rdata = 32'd0;
    idle();
    step();
    step();
    cmp_en = 1'b1;
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_wb", {30'd0, wb_WB}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b0;

    // ALU pass-through
    res = 32'h10; wr = 5'd5; wbm = 2'b10; m = 3'b000;
    #1 chk("alu_stall", {31'd0, stall_mem}, 32'd0);
    step();
    chk("alu_res", alu_res_wb, 32'h10);
    chk("alu_rd", {27'd0, rd_WB}, 32'd5);
    chk("alu_wb", {30'd0, wb_WB}, 32'd2);
    chk("alu_wdr", write_data_reg, 32'h10);
    idle();
    step();

    // Load with ack three cycles after the request
    res = 32'h100; wr = 5'd7; wbm = 2'b11; m = 3'b010;
    #1 chk("ld_stall_entry", {31'd0, stall_mem}, 32'd1);
    step();
    chk("ld_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("ld_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("ld_addr", bus.dmem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      #1 chk("ld_stall_wait", {31'd0, stall_mem}, 32'd1);
      step();
    end
    ack = 1'b1; rdata = 32'hDEADBEEF;
    #1 chk("ld_stall_ack", {31'd0, stall_mem}, 32'd0);
    step();
    ack = 1'b0; rdata = 32'd0;
    chk("ld_rdwb", read_data_wb, 32'hDEADBEEF);
    chk("ld_wdr", write_data_reg, 32'hDEADBEEF);
    chk("ld_req_drop", {31'd0, bus.dmem_req}, 32'd0);
    idle();
    step();

    // Store with immediate ack
    res = 32'h204; wd = 32'h12345678; wr = 5'd0; wbm = 2'b00; m = 3'b001;
    step();
    chk("st_we", {31'd0, bus.dmem_we}, 32'd1);
    chk("st_wdata", bus.dmem_wdata, 32'h12345678);
    ack = 1'b1;
    #1 chk("st_stall", {31'd0, stall_mem}, 32'd0);
    step();
    ack = 1'b0;
    chk("st_wb", {30'd0, wb_WB}, 32'd0);
    chk("st_req", {31'd0, bus.dmem_req}, 32'd0);
    idle();
    step();

    // Misaligned load
    res = 32'h102; wr = 5'd4; wbm = 2'b11; m = 3'b010;
    #1 chk("mis_stall", {31'd0, stall_mem}, 32'd0);
    step();
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_wb", {30'd0, wb_WB}, 32'd0);
    chk("mis_req", {31'd0, bus.dmem_req}, 32'd0);
    idle();
    step();
    chk("mis_clear", {31'd0, misalign}, 32'd0);

    // Load never acknowledged: timeout
    res = 32'h300; wr = 5'd3; wbm = 2'b11; m = 3'b010;
    step();
    for (int i = 0; i < TO; i++) begin
      #1 chk("to_stall_wait", {31'd0, stall_mem}, 32'd1);
      step();
    end
    #1 chk("to_stall_rel", {31'd0, stall_mem}, 32'd0);
    step();
    chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_req", {31'd0, bus.dmem_req}, 32'd0);
    idle();
    step();
    step();
    chk("to_err_sticky", {31'd0, bus_err}, 32'd1);

    // Reset during BUSY, late ack ignored
    res = 32'h400; wr = 5'd9; wbm = 2'b11; m = 3'b010; zero = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    ack = 1'b1; rdata = 32'hCAFEF00D;
    chk("rs_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rs_addr", bus.dmem_addr, 32'd0);
    chk("rs_rdwb", read_data_wb, 32'd0);
    chk("rs_alu", alu_res_wb, 32'd0);
    chk("rs_err", {31'd0, bus_err}, 32'd0);
    step();
    ack = 1'b0; rdata = 32'd0;
    chk("rs_late_ack", read_data_wb, 32'd0);
    chk("rs_late_req", {31'd0, bus.dmem_req}, 32'd0);

    // Branch taken in IDLE
    m = 3'b100; zero = 1'b1;
    #1 chk("br_pc_src", {31'd0, pc_src}, 32'd1);
    step();
    idle();
    step();
    step();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
